// File: rtl/sensor_debounce.sv
// Sensor input conditioner: 2-flop synchroniser, per-channel debounce, edge pulses and active count.
// Define SENSOR_DEBOUNCE_STICKY_EN to build the sticky rise register behind event_latched.
module sensor_debounce #(
  parameter int NUM_CH          = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NUM_CH-1:0] sensor_raw,
  output logic [NUM_CH-1:0] sensor_stable,
  output logic [NUM_CH-1:0] sensor_rise,
  output logic [NUM_CH-1:0] sensor_fall,
  output logic [3:0]        active_count,
  output logic              any_active,
  input  logic              clr_events,
  output logic [NUM_CH-1:0] event_latched
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] stable_q, stable_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [3:0]        count_q, count_d;
  logic              any_q;

  // A channel only moves once the synchronised level has disagreed with it for DEBOUNCE_CYCLES edges.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = sync2_q[i];
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      count_d = count_d + {3'b000, stable_q[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      count_q  <= '0;
      any_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (ena) begin
      sync1_q  <= sensor_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      count_q  <= count_d;
      any_q    <= |stable_q;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end else begin
      rise_q <= '0;
      fall_q <= '0;
    end
  end

  assign sensor_stable = stable_q;
  assign sensor_rise   = rise_q;
  assign sensor_fall   = fall_q;
  assign active_count  = count_q;
  assign any_active    = any_q;

`ifdef SENSOR_DEBOUNCE_STICKY_EN
  logic [NUM_CH-1:0] event_q;

  // Set beats clear so a rise coinciding with a clear is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      event_q <= '0;
    end else if (ena) begin
      event_q <= (event_q & ~{NUM_CH{clr_events}}) | rise_d;
    end
  end

  assign event_latched = event_q;
`else
  logic unusedClr;
  assign unusedClr     = clr_events;
  assign event_latched = '0;
`endif

endmodule

// File: tb/tb_sensor_debounce.sv
// Self-checking bench for sensor_debounce: constant vector table, hand-written corner sequences
// and randomized stimulus compared against a sample-history reference model.
module tb_sensor_debounce;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] sensorRaw;
  logic       clrEvents;
  logic [7:0] sensorStable;
  logic [7:0] sensorRise;
  logic [7:0] sensorFall;
  logic [3:0] activeCount;
  logic       anyActive;
  logic [7:0] eventLatched;

  int checks = 0;
  int errors = 0;

  logic [7:0] mSync1, mSync2, mStable, mRise, mFall, mEvent;
  logic [3:0] mCount;
  logic       mAny;
  logic [7:0] hist[$];

  typedef struct {
    logic [7:0] raw;
    int         hold;
    logic [7:0] expStable;
    logic [3:0] expCount;
    logic       expAny;
  } vec_t;

  vec_t vecs[8];

  sensor_debounce #(.NUM_CH(8), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .sensor_raw   (sensorRaw),
    .sensor_stable(sensorStable),
    .sensor_rise  (sensorRise),
    .sensor_fall  (sensorFall),
    .active_count (activeCount),
    .any_active   (anyActive),
    .clr_events   (clrEvents),
    .event_latched(eventLatched)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // A channel flips when its last DEB enabled synchronised samples all disagree with it.
  task automatic updateModel(input logic [7:0] raw, input logic en, input logic rs, input logic clr);
    logic [7:0] prevStable;
    logic       allDiff;
    if (rs) begin
      mSync1 = '0; mSync2 = '0; mStable = '0; mRise = '0; mFall = '0;
      mCount = '0; mAny = 1'b0; mEvent = '0;
      hist.delete();
    end else if (!en) begin
      mRise = '0;
      mFall = '0;
    end else begin
      prevStable = mStable;
      hist.push_back(mSync2);
      if (hist.size() > DEB) void'(hist.pop_front());
      mSync2 = mSync1;
      mSync1 = raw;
      mRise = '0;
      mFall = '0;
      if (hist.size() == DEB) begin
        for (int ch = 0; ch < 8; ch++) begin
          allDiff = 1'b1;
          foreach (hist[k]) if (hist[k][ch] == prevStable[ch]) allDiff = 1'b0;
          if (allDiff) begin
            mStable[ch] = ~prevStable[ch];
            mRise[ch]   = ~prevStable[ch];
            mFall[ch]   = prevStable[ch];
          end
        end
      end
      mCount = 4'($countones(prevStable));
      mAny   = |prevStable;
`ifdef SENSOR_DEBOUNCE_STICKY_EN
      mEvent = (clr ? 8'h00 : mEvent) | mRise;
`else
      mEvent = '0;
      if (clr) mEvent = '0;
`endif
    end
  endtask

  task automatic applyStimulus(input logic [7:0] raw, input logic en, input logic rs, input logic clr);
    sensorRaw = raw;
    ena       = en;
    rst       = rs;
    clrEvents = clr;
    @(posedge clk);
    updateModel(raw, en, rs, clr);
    #1;
    checkOutput("model_stable", sensorStable, mStable);
    checkOutput("model_rise", sensorRise, mRise);
    checkOutput("model_fall", sensorFall, mFall);
    checkOutput("model_count", activeCount, mCount);
    checkOutput("model_any", anyActive, mAny);
    checkOutput("model_event", eventLatched, mEvent);
  endtask

  task automatic step(input logic [7:0] raw, input logic en);
    applyStimulus(raw, en, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] seenPulse;
    logic [7:0] rawR;

    vecs[0] = '{raw: 8'h00, hold: 8, expStable: 8'h00, expCount: 4'd0, expAny: 1'b0};
    vecs[1] = '{raw: 8'hA5, hold: 8, expStable: 8'hA5, expCount: 4'd4, expAny: 1'b1};
    vecs[2] = '{raw: 8'h5A, hold: 8, expStable: 8'h5A, expCount: 4'd4, expAny: 1'b1};
    vecs[3] = '{raw: 8'hFF, hold: 8, expStable: 8'hFF, expCount: 4'd8, expAny: 1'b1};
    vecs[4] = '{raw: 8'h01, hold: 8, expStable: 8'h01, expCount: 4'd1, expAny: 1'b1};
    vecs[5] = '{raw: 8'h80, hold: 9, expStable: 8'h80, expCount: 4'd1, expAny: 1'b1};
    vecs[6] = '{raw: 8'h3C, hold: 8, expStable: 8'h3C, expCount: 4'd4, expAny: 1'b1};
    vecs[7] = '{raw: 8'h00, hold: 8, expStable: 8'h00, expCount: 4'd0, expAny: 1'b0};

    // Reset with all pins high, then latency to acceptance and to the count.
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0);
    checkOutput("reset_stable", sensorStable, 8'h00);
    checkOutput("reset_count", activeCount, 4'd0);
    checkOutput("reset_any", anyActive, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step(8'hFF, 1'b1);
      if (i == 5) checkOutput("lat_stable_e5", sensorStable, 8'h00);
      if (i == 6) begin
        checkOutput("lat_stable_e6", sensorStable, 8'hFF);
        checkOutput("lat_rise_e6", sensorRise, 8'hFF);
        checkOutput("lat_count_e6", activeCount, 4'd0);
      end
      if (i == 7) begin
        checkOutput("lat_count_e7", activeCount, 4'd8);
        checkOutput("lat_any_e7", anyActive, 1'b1);
        checkOutput("lat_rise_e7", sensorRise, 8'h00);
      end
    end

    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].hold; i++) step(vecs[v].raw, 1'b1);
      checkOutput($sformatf("vec%0d_stable", v), sensorStable, vecs[v].expStable);
      checkOutput($sformatf("vec%0d_count", v), activeCount, vecs[v].expCount);
      checkOutput($sformatf("vec%0d_any", v), anyActive, vecs[v].expAny);
    end

    // Single channel rise then release.
    for (int i = 1; i <= 10; i++) begin
      step(8'h01, 1'b1);
      if (i == 5) checkOutput("ch0_stable_e5", sensorStable, 8'h00);
      if (i == 6) checkOutput("ch0_rise_e6", sensorRise, 8'h01);
      if (i == 7) checkOutput("ch0_rise_e7", sensorRise, 8'h00);
    end
    for (int i = 1; i <= 8; i++) begin
      step(8'h00, 1'b1);
      if (i == 5) checkOutput("ch0_fall_e5", sensorFall, 8'h00);
      if (i == 6) checkOutput("ch0_fall_e6", sensorFall, 8'h01);
      if (i == 7) checkOutput("ch0_fall_e7", sensorFall, 8'h00);
    end

    // Glitch of 3 cycles is rejected; 4 cycles is accepted.
    seenPulse = '0;
    for (int i = 0; i < 3; i++) begin step(8'h02, 1'b1); seenPulse |= sensorRise | sensorFall; end
    for (int i = 0; i < 8; i++) begin step(8'h00, 1'b1); seenPulse |= sensorRise | sensorFall; end
    checkOutput("glitch3_pulses", seenPulse, 8'h00);
    checkOutput("glitch3_stable", sensorStable, 8'h00);
    for (int i = 0; i < 4; i++) step(8'h02, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    checkOutput("glitch4_stable", sensorStable, 8'h02);
    checkOutput("glitch4_rise", sensorRise, 8'h02);
    for (int i = 0; i < 8; i++) step(8'h00, 1'b1);

    // Two channels rise together.
    for (int i = 1; i <= 6; i++) step(8'h06, 1'b1);
    checkOutput("combo_rise", sensorRise, 8'h06);
    step(8'h06, 1'b1);
    checkOutput("combo_count", activeCount, 4'd2);

    // Enable dropped mid-count, then resumed.
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
    checkOutput("ena_pre_stable", sensorStable, 8'h06);
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 1'b0);
      checkOutput("ena_hold_pulses", sensorRise | sensorFall, 8'h00);
      checkOutput("ena_hold_stable", sensorStable, 8'h06);
      checkOutput("ena_hold_count", activeCount, 4'd2);
    end
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    checkOutput("ena_resume_r2", sensorStable, 8'h06);
    step(8'h00, 1'b1);
    checkOutput("ena_resume_r3", sensorStable, 8'h00);
    checkOutput("ena_resume_fall", sensorFall, 8'h06);

    // Randomized run with slowly toggling pins, occasional enable drops and resets.
    rawR = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int ch = 0; ch < 8; ch++) begin
        if ($urandom_range(0, 5) == 0) rawR[ch] = ~rawR[ch];
      end
      applyStimulus(rawR, $urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0,
                    $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
